// File: rtl/saisie_de.sv
// Keypad entry decoder: gathers up to three decimal digits, checks them against the
// supported dice set on ENTER and emits the dice code, echoing typed digits meanwhile.
module saisie_de #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [2:0] dice,
    output logic       dice_valid,
    output logic       error,
    output logic       busy,
    output logic [3:0] ent_unit,
    output logic [3:0] ent_diz,
    output logic [3:0] ent_cent
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ENTRY = 1'b1;

    localparam logic [3:0] BLANK     = 4'd15;
    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;

    logic [0:0]    state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    dice_reg, dice_next;
    logic          dice_valid_reg, dice_valid_next;
    logic          error_reg, error_next;

    // digit_reg[0] is the newest digit (units), digit_reg[2] the oldest (hundreds)
    logic [3:0] digit_reg  [3];
    logic [3:0] digit_next [3];
    logic [3:0] digit_val  [3];

    logic       key_is_digit;
    logic       key_accepted;
    logic       set_hit;
    logic [2:0] set_code;

    assign key_is_digit = (key_code <= 4'd9);
    assign key_accepted = key_valid && (key_code <= KEY_CLEAR);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign digit_val[gi] = (digit_reg[gi] == BLANK) ? 4'd0 : digit_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_reg[gi] <= BLANK;
                end else begin
                    digit_reg[gi] <= digit_next[gi];
                end
            end
        end
    endgenerate

    // The set is matched directly on the three BCD digits; blanks count as zero.
    always_comb begin
        set_hit  = 1'b1;
        set_code = 3'd0;
        case ({digit_val[2], digit_val[1], digit_val[0]})
            12'h004: set_code = 3'd0;
            12'h006: set_code = 3'd1;
            12'h008: set_code = 3'd2;
            12'h010: set_code = 3'd3;
            12'h012: set_code = 3'd4;
            12'h020: set_code = 3'd5;
            12'h030: set_code = 3'd6;
            12'h100: set_code = 3'd7;
            default: set_hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        timer_next      = timer_reg;
        dice_next       = dice_reg;
        dice_valid_next = 1'b0;
        error_next      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            digit_next[i] = digit_reg[i];
        end

        if (state_reg == S_ENTRY) begin
            timer_next = timer_reg + 1'b1;
        end

        if (key_accepted) begin
            timer_next = '0;
            if (key_is_digit && (cnt_reg != 2'd3)) begin
                digit_next[2] = digit_reg[1];
                digit_next[1] = digit_reg[0];
                digit_next[0] = key_code;
                cnt_next      = cnt_reg + 2'd1;
                state_next    = S_ENTRY;
            end else if (key_code == KEY_ENTER && state_reg == S_IDLE) begin
                error_next = 1'b1;
            end else begin
                // Overflow digit, ENTER from ENTRY, or CLEAR: all end the entry.
                if (key_is_digit) begin
                    error_next = 1'b1;
                end else if (key_code == KEY_ENTER) begin
                    if (set_hit) begin
                        dice_next       = set_code;
                        dice_valid_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
                cnt_next   = 2'd0;
                state_next = S_IDLE;
                for (int i = 0; i < 3; i++) begin
                    digit_next[i] = BLANK;
                end
            end
        end else if (state_reg == S_ENTRY && timer_reg == TIMER_LAST) begin
            timer_next = '0;
            cnt_next   = 2'd0;
            state_next = S_IDLE;
            for (int i = 0; i < 3; i++) begin
                digit_next[i] = BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 2'd0;
            timer_reg      <= '0;
            dice_reg       <= 3'd0;
            dice_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            timer_reg      <= timer_next;
            dice_reg       <= dice_next;
            dice_valid_reg <= dice_valid_next;
            error_reg      <= error_next;
        end
    end

    assign dice       = dice_reg;
    assign dice_valid = dice_valid_reg;
    assign error      = error_reg;
    assign busy       = (state_reg == S_ENTRY);
    assign ent_unit   = digit_reg[0];
    assign ent_diz    = digit_reg[1];
    assign ent_cent   = digit_reg[2];

endmodule

// File: tb/tb_saisie_de.sv
// Directed bench for saisie_de with TIMEOUT=16; expected values are hand-computed.
module tb_saisie_de;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] dice;
    logic       dice_valid;
    logic       error;
    logic       busy;
    logic [3:0] ent_unit;
    logic [3:0] ent_diz;
    logic [3:0] ent_cent;

    int checks = 0;
    int errors = 0;

    saisie_de #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .dice       (dice),
        .dice_valid (dice_valid),
        .error      (error),
        .busy       (busy),
        .ent_unit   (ent_unit),
        .ent_diz    (ent_diz),
        .ent_cent   (ent_cent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One-cycle strobe; returns on the falling edge after the sampling edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_cent"}, int'(ent_cent), 15);
        check({tag, "_diz"},  int'(ent_diz),  15);
        check({tag, "_unit"}, int'(ent_unit), 15);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_seen;
        rst       = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd5;
        repeat (3) @(negedge clk);
        check("rst_dice", int'(dice), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dv",   int'(dice_valid), 0);
        check("rst_err",  int'(error), 0);
        check_blank("rst");
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;

        // "20" -> D20
        press(4'd2);
        check("k2_unit", int'(ent_unit), 2);
        check("k2_busy", int'(busy), 1);
        press(4'd0);
        check("k20_cent", int'(ent_cent), 15);
        check("k20_diz",  int'(ent_diz), 2);
        check("k20_unit", int'(ent_unit), 0);
        check("k20_busy", int'(busy), 1);
        press(4'd10);
        check("d20_dice", int'(dice), 5);
        check("d20_dv",   int'(dice_valid), 1);
        check("d20_busy", int'(busy), 0);
        check_blank("d20");
        @(negedge clk);
        check("d20_dv_end", int'(dice_valid), 0);

        // "004" -> D4 (leading zeros)
        press(4'd0); press(4'd0); press(4'd4); press(4'd10);
        check("d4_dice", int'(dice), 0);
        check("d4_dv",   int'(dice_valid), 1);

        // "100" -> D100
        press(4'd1); press(4'd0); press(4'd0); press(4'd10);
        check("d100_dice", int'(dice), 7);
        check("d100_dv",   int'(dice_valid), 1);

        // "7" is not in the set
        press(4'd7); press(4'd10);
        check("d7_err",  int'(error), 1);
        check("d7_dv",   int'(dice_valid), 0);
        check("d7_dice", int'(dice), 7);
        check("d7_busy", int'(busy), 0);

        // fourth digit overflows
        press(4'd1); press(4'd2); press(4'd3);
        check("ovf_cent", int'(ent_cent), 1);
        press(4'd4);
        check("ovf_err",  int'(error), 1);
        check("ovf_busy", int'(busy), 0);
        check_blank("ovf");
        @(negedge clk);
        check("ovf_err_end", int'(error), 0);
        press(4'd10);
        check("idle_enter_err",  int'(error), 1);
        check("idle_enter_dice", int'(dice), 7);

        // timeout: busy falls 16 cycles after the sample edge
        press(4'd3);
        err_seen = 0;
        repeat (15) begin
            @(negedge clk);
            err_seen = err_seen | int'(error);
        end
        check("to_busy_before", int'(busy), 1);
        @(negedge clk);
        err_seen = err_seen | int'(error);
        check("to_busy_after", int'(busy), 0);
        check("to_no_err", err_seen, 0);
        check_blank("to");

        // ignored key does not restart the timer
        press(4'd3);
        repeat (6) @(negedge clk);
        press(4'd13);
        check("ign_unit", int'(ent_unit), 3);
        check("ign_diz",  int'(ent_diz), 15);
        repeat (7) @(negedge clk);
        check("ign_busy_before", int'(busy), 1);
        @(negedge clk);
        check("ign_busy_after", int'(busy), 0);

        // CLEAR then "6"
        press(4'd1); press(4'd2); press(4'd11);
        check("clr_err",  int'(error), 0);
        check("clr_dv",   int'(dice_valid), 0);
        check("clr_busy", int'(busy), 0);
        check_blank("clr");
        press(4'd6); press(4'd10);
        check("d6_dice", int'(dice), 1);
        check("d6_dv",   int'(dice_valid), 1);

        // back-to-back strobes, key right after ENTER
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd8;
        @(negedge clk);
        key_code  = 4'd10;
        @(negedge clk);
        check("b2b_dice", int'(dice), 2);
        check("b2b_dv",   int'(dice_valid), 1);
        check("b2b_busy", int'(busy), 0);
        key_code  = 4'd1;
        @(negedge clk);
        key_valid = 1'b0;
        check("b2b_next_busy", int'(busy), 1);
        check("b2b_next_unit", int'(ent_unit), 1);
        check("b2b_next_dv",   int'(dice_valid), 0);

        // reset mid-entry
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_dice", int'(dice), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_err",  int'(error), 0);
        check_blank("mrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saisie_de.md
# saisie_de

Keypad entry decoder for the dice selector. It accumulates up to three decimal key presses into a number and validates it against the supported dice set {4, 6, 8, 10, 12, 20, 30, 100}. On ENTER it emits the 3-bit dice code, using the same code map the display separator consumes. It sits between the keypad scanner and the dice register, and echoes the digits typed so far on 7-segment digit codes.

## Interface
- TIMEOUT, default 50_000_000: idle cycles in entry before the buffer is silently cleared. Must be ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is sampled only when this is high.
- key_code  in  4  0–9 are digits, 10 is ENTER, 11 is CLEAR, 12–15 are ignored (no state change, no timer restart).
- dice  out  3  last accepted dice code: D4=0, D6=1, D8=2, D10=3, D12=4, D20=5, D30=6, D100=7.
- dice_valid  out  1  one-cycle pulse when dice is updated.
- error  out  1  one-cycle pulse on rejected entry.
- busy  out  1  high while in ENTRY.
- ent_unit, ent_diz, ent_cent  out  4 each  echo of typed digits, 0–9, or 15 = blank.

## Operation
- States are IDLE and ENTRY. The digit buffer holds cnt (0–3) digits, newest in ent_unit; earlier digits shift left toward ent_cent.
- Digit, from IDLE or ENTRY with cnt < 3: shift it in, cnt+1, go to ENTRY, restart the timer.
- Digit with cnt = 3: pulse error, clear the buffer (all echoes 15, cnt 0), go to IDLE.
- ENTER in ENTRY: evaluate value = 100·cent + 10·diz + unit, treating blank digits as 0. Leading zeros are legal, so "004" equals 4.
  - If the value is in the set: load dice with its code, pulse dice_valid.
  - Otherwise: pulse error and leave dice unchanged.
  - In both cases clear the buffer and go to IDLE.
- ENTER in IDLE: pulse error; nothing else changes.
- CLEAR: clear the buffer and go to IDLE with no pulse. It is a no-op in IDLE.
- Timeout: in ENTRY, after TIMEOUT consecutive cycles with no accepted key (codes 0–11), clear the buffer and go to IDLE. No error pulse.
- The comparison is done on the digits directly (4-bit BCD per digit); no binary conversion is required.

## Timing
- Reset values: dice=0, dice_valid=0, error=0, busy=0, all echoes=15, state IDLE, cnt=0, timer=0. rst wins over a simultaneous key_valid.
- All outputs are registered.
- Digit: echo and busy update on the cycle after the key_valid sample (latency 1).
- ENTER: dice, dice_valid or error, cleared echoes and busy=0 all appear together on cycle +1. Pulses last exactly one cycle.
- A key_valid on the cycle right after ENTER is processed normally from IDLE. Back-to-back strobes are accepted every cycle.
- Timer: resets to 0 on each accepted key. The clear takes effect on the edge where the timer reaches TIMEOUT−1, so busy drops TIMEOUT cycles after the last key's sample edge.
- A key accepted on the same cycle as timer expiry takes priority; the timer restarts.
- rst mid-entry: buffer cleared, no pulse, dice returns to 0.

## Test plan
- Reset → dice=0, busy=0, echoes 15/15/15, no pulses. Hold rst with key_valid=1, key=5 → still in the reset state.
- Keys 2, 0, ENTER → one cycle after ENTER: dice=5, dice_valid=1 for 1 cycle, echoes blank. After the first two keys the echo reads cent=15, diz=2, unit=0 and busy=1.
- Keys 1, 0, 0, ENTER → dice=7. Keys 0, 0, 4, ENTER → dice=0. Keys 7, ENTER → error pulse, dice keeps its prior value.
- Keys 1, 2, 3, 4 → error pulse on the cycle after the fourth key, echoes blank, busy=0. A following ENTER → error again (IDLE case).
- With TIMEOUT=16: key 3, then no keys → busy falls 16 cycles after the sample edge, echoes blank, no error. Key 3, key 13 at cycle 8 → the timer is not restarted.
- Keys 1, 2, CLEAR, 6, ENTER → no pulse at CLEAR, then dice=1 with dice_valid.
